// File: rtl/present_sbox_layer_if.sv
// Handshake and data bundle for present_sbox_layer: input word channel plus result channel.
// The slave modport is the S-box layer; the master modport is whoever feeds and drains it.
interface present_sbox_layer_if #(
   parameter int NIBBLES = 16
);
   logic                   i_valid;
   logic                   i_ready;
   logic                   i_mode;
   logic [4*NIBBLES-1:0]   idat;
   logic                   o_valid;
   logic                   o_ready;
   logic [4*NIBBLES-1:0]   odat;

   modport master (
      output i_valid, i_mode, idat, o_ready,
      input  i_ready, o_valid, odat
   );

   modport slave (
      input  i_valid, i_mode, idat, o_ready,
      output i_ready, o_valid, odat
   );
endinterface

// File: rtl/present_sbox_layer.sv
// PRESENT S-box layer: applies LANES 4-bit S-boxes per cycle, LSB group first, over a NIBBLES-wide word.
// Define PRESENT_SBOX_INV_EN to add per-lane inverse S-boxes selected by i_mode; otherwise only forward.
module present_sbox_layer #(
   parameter int NIBBLES = 16,
   parameter int LANES   = 4
) (
   input  logic               clk,
   input  logic               rst,
   present_sbox_layer_if.slave bus
);

   localparam int GROUPS = NIBBLES / LANES;
   localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
   localparam int W      = 4 * NIBBLES;
   localparam int GW     = 4 * LANES;
   localparam int IW     = $clog2(W);
   localparam logic [CW-1:0] LAST = CW'(GROUPS - 1);

   generate
      if (LANES < 1 || (NIBBLES % LANES) != 0) begin : g_param_check
         $error("present_sbox_layer: NIBBLES must be a positive multiple of LANES");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    work_q, work_d;
   logic [IW-1:0]   lo;
   logic [GW-1:0]   grp;
   logic [GW-1:0]   grp_sub;

   function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'hC;
         4'h1: y = 4'h5;
         4'h2: y = 4'h6;
         4'h3: y = 4'hB;
         4'h4: y = 4'h9;
         4'h5: y = 4'h0;
         4'h6: y = 4'hA;
         4'h7: y = 4'hD;
         4'h8: y = 4'h3;
         4'h9: y = 4'hE;
         4'hA: y = 4'hF;
         4'hB: y = 4'h8;
         4'hC: y = 4'h4;
         4'hD: y = 4'h7;
         4'hE: y = 4'h1;
         default: y = 4'h2;
      endcase
      return y;
   endfunction

`ifdef PRESENT_SBOX_INV_EN
   logic mode_q, mode_d;

   function automatic logic [3:0] sbox_inv(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'h5;
         4'h1: y = 4'hE;
         4'h2: y = 4'hF;
         4'h3: y = 4'h8;
         4'h4: y = 4'hC;
         4'h5: y = 4'h1;
         4'h6: y = 4'h2;
         4'h7: y = 4'hD;
         4'h8: y = 4'hB;
         4'h9: y = 4'h4;
         4'hA: y = 4'h6;
         4'hB: y = 4'h3;
         4'hC: y = 4'h0;
         4'hD: y = 4'h7;
         4'hE: y = 4'h9;
         default: y = 4'hA;
      endcase
      return y;
   endfunction

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign grp_sub[4*l +: 4] = mode_q ? sbox_inv(grp[4*l +: 4]) : sbox_fwd(grp[4*l +: 4]);
   end
`else
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign grp_sub[4*l +: 4] = sbox_fwd(grp[4*l +: 4]);
   end
`endif

   // Bit offset of the nibble group the lane counter currently points at.
   assign lo  = IW'(int'(cnt_q) * GW);
   assign grp = work_q[lo +: GW];

   // Next-state logic: load on acceptance, substitute one group per BUSY cycle, hold in DONE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
`ifdef PRESENT_SBOX_INV_EN
      mode_d  = mode_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.i_valid) begin
               work_d  = bus.idat;
`ifdef PRESENT_SBOX_INV_EN
               mode_d  = bus.i_mode;
`endif
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            work_d[lo +: GW] = grp_sub;
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (bus.o_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; reset abandons any word in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         work_q  <= '0;
`ifdef PRESENT_SBOX_INV_EN
         mode_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
`ifdef PRESENT_SBOX_INV_EN
         mode_q  <= mode_d;
`endif
      end
   end

   assign bus.i_ready = (state_q == IDLE);
   assign bus.o_valid = (state_q == DONE);
   assign bus.odat    = work_q;

endmodule

// File: tb/tb_present_sbox_layer.sv
// Testbench for present_sbox_layer: three instances (LANES 4, 16, 1) driven with directed and random
// words and compared against a table-lookup reference model.
module tb_present_sbox_layer;

   // Table nibble i holds S(i); read with a plain shift-and-mask lookup.
   localparam logic [63:0] FWD_TBL = 64'h21748FE3DA09B65C;
   localparam logic [63:0] INV_TBL = 64'hA970364BD21C8FE5;
`ifdef PRESENT_SBOX_INV_EN
   localparam bit INV_EN = 1'b1;
`else
   localparam bit INV_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  iv, im, ordy, ir, ov;
   logic [63:0] id [3];
   logic [63:0] od [3];
   int          assertCount = 0;
   int          failCount = 0;
   logic [63:0] got;

   always #5 clk = ~clk;

   present_sbox_layer_if #(.NIBBLES(16)) bus0 ();
   present_sbox_layer_if #(.NIBBLES(16)) bus1 ();
   present_sbox_layer_if #(.NIBBLES(16)) bus2 ();

   present_sbox_layer #(.NIBBLES(16), .LANES(4))  dut0 (.clk(clk), .rst(rst), .bus(bus0));
   present_sbox_layer #(.NIBBLES(16), .LANES(16)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   present_sbox_layer #(.NIBBLES(16), .LANES(1))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

   assign bus0.i_valid = iv[0];
   assign bus0.i_mode  = im[0];
   assign bus0.idat    = id[0];
   assign bus0.o_ready = ordy[0];
   assign bus1.i_valid = iv[1];
   assign bus1.i_mode  = im[1];
   assign bus1.idat    = id[1];
   assign bus1.o_ready = ordy[1];
   assign bus2.i_valid = iv[2];
   assign bus2.i_mode  = im[2];
   assign bus2.idat    = id[2];
   assign bus2.o_ready = ordy[2];

   always_comb begin
      ir    = {bus2.i_ready, bus1.i_ready, bus0.i_ready};
      ov    = {bus2.o_valid, bus1.o_valid, bus0.o_valid};
      od[0] = bus0.odat;
      od[1] = bus1.odat;
      od[2] = bus2.odat;
   end

   function automatic int latencyOf(input int w);
      case (w)
         0:       return 4;
         1:       return 1;
         default: return 16;
      endcase
   endfunction

   function automatic logic [63:0] refWord(input logic [63:0] d, input logic useInv);
      logic [63:0] tbl;
      logic [63:0] r;
      tbl = useInv ? INV_TBL : FWD_TBL;
      r = '0;
      for (int k = 0; k < 16; k++) begin
         r[4*k +: 4] = tbl[int'(d[4*k +: 4]) * 4 +: 4];
      end
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // Offer one word to instance w, keep junk on the inputs while it works, stall the result, then drain it.
   task automatic applyStimulus(input int w, input logic [63:0] d, input logic m, input int stall,
                                input string tag, output logic [63:0] result);
      logic [63:0] expected;
      int lat;
      expected = refWord(d, m && INV_EN);
      @(negedge clk);
      checkOutput({tag, "_iready_idle"}, 64'(ir[w]), 64'd1);
      iv[w] = 1'b1;
      im[w] = m;
      id[w] = d;
      @(negedge clk);
      im[w] = ~m;
      id[w] = {$urandom, $urandom};
      lat = 0;
      while (!ov[w] && lat < 64) begin
         @(negedge clk);
         lat++;
         id[w] = {$urandom, $urandom};
      end
      checkOutput({tag, "_latency"}, 64'(lat), 64'(latencyOf(w)));
      checkOutput({tag, "_odat"}, od[w], expected);
      result = od[w];
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         checkOutput({tag, "_hold_ovalid"}, 64'(ov[w]), 64'd1);
         checkOutput({tag, "_hold_odat"}, od[w], expected);
         checkOutput({tag, "_hold_iready"}, 64'(ir[w]), 64'd0);
      end
      iv[w]   = 1'b0;
      ordy[w] = 1'b1;
      @(negedge clk);
      ordy[w] = 1'b0;
      checkOutput({tag, "_drain_ovalid"}, 64'(ov[w]), 64'd0);
      checkOutput({tag, "_drain_iready"}, 64'(ir[w]), 64'd1);
   endtask

   initial begin
      iv   = '0;
      im   = '0;
      ordy = '0;
      for (int w = 0; w < 3; w++) id[w] = '0;

      repeat (2) @(negedge clk);
      for (int w = 0; w < 3; w++) begin
         checkOutput("reset_odat", od[w], 64'd0);
         checkOutput("reset_ovalid", 64'(ov[w]), 64'd0);
         checkOutput("reset_iready", 64'(ir[w]), 64'd1);
      end
      rst = 1'b0;

      applyStimulus(0, 64'h0123456789ABCDEF, 1'b0, 0, "fwd_vector", got);
      checkOutput("fwd_vector_const", got, 64'hC56B90AD3EF84712);

      applyStimulus(0, 64'hC56B90AD3EF84712, 1'b1, 0, "mode1_vector", got);
      if (INV_EN) checkOutput("inv_vector_const", got, 64'h0123456789ABCDEF);

      applyStimulus(0, 64'hDEADBEEFCAFEF00D, 1'b0, 5, "backpressure", got);

      // Abort a word mid-flight with an asynchronous reset pulse.
      @(negedge clk);
      iv[0] = 1'b1;
      im[0] = 1'b0;
      id[0] = 64'h0F1E2D3C4B5A6978;
      @(negedge clk);
      iv[0] = 1'b0;
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      checkOutput("busy_reset_odat", od[0], 64'd0);
      checkOutput("busy_reset_ovalid", 64'(ov[0]), 64'd0);
      checkOutput("busy_reset_iready", 64'(ir[0]), 64'd1);
      #1 rst = 1'b0;
      applyStimulus(0, 64'h0F1E2D3C4B5A6978, 1'b0, 1, "after_reset", got);

      applyStimulus(1, 64'hFFFFFFFFFFFFFFFF, 1'b0, 0, "lanes16", got);
      checkOutput("lanes16_const", got, 64'h2222222222222222);
      applyStimulus(2, 64'h0123456789ABCDEF, 1'b0, 2, "lanes1", got);
      checkOutput("lanes1_const", got, 64'hC56B90AD3EF84712);

      for (int n = 0; n < 20; n++) begin
         for (int w = 0; w < 3; w++) begin
            applyStimulus(w, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 3)), $sformatf("rand%0d_%0d", w, n), got);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
